// File: rtl/majority_voter_seq.sv
// Registered N-channel, W-bit bitwise majority voter with per-channel consecutive-mismatch fault tracking.
// Latency 1 cycle; no backpressure, a sample is accepted whenever IN_VALID is high.
module majority_voter_seq #(
  parameter int N         = 3,
  parameter int W         = 8,
  parameter int ERR_LIMIT = 4
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           IN_VALID,
  input  logic [N*W-1:0] IN_DATA,
  input  logic           MASK_EN,
  input  logic           CLR_FAULT,
  output logic           OUT_VALID,
  output logic [W-1:0]   OUT_DATA,
  output logic [N-1:0]   MISMATCH,
  output logic [N-1:0]   FAULT,
  output logic           ALL_FAULT
);

  localparam int CW = $clog2(ERR_LIMIT + 1);
  localparam int NW = $clog2(N + 1);

  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAULT} state_t;

  state_t        st_q  [N];
  state_t        st_d  [N];
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [N-1:0]  mismatch_q, mismatch_d;
  logic [N-1:0]  fault_q, fault_d;

  logic [W-1:0]  voted;
  logic [N-1:0]  active;
  logic [N-1:0]  chan_mm;
  logic [NW-1:0] n_act;
  logic [NW-1:0] n_ones;

  // Ties (even active count, including zero) keep the previous output bit.
  always_comb begin
    active = MASK_EN ? ~fault_q : '1;
    voted  = out_data_q;
    n_act  = '0;
    n_ones = '0;
    for (int k = 0; k < N; k++) begin
      if (active[k]) n_act = n_act + NW'(1);
    end
    for (int b = 0; b < W; b++) begin
      n_ones = '0;
      for (int k = 0; k < N; k++) begin
        if (active[k] && IN_DATA[k*W+b]) n_ones = n_ones + NW'(1);
      end
      if (n_ones > (n_act - n_ones))      voted[b] = 1'b1;
      else if (n_ones < (n_act - n_ones)) voted[b] = 1'b0;
      else                                voted[b] = out_data_q[b];
    end
    for (int k = 0; k < N; k++) begin
      chan_mm[k] = (IN_DATA[k*W +: W] != voted);
    end
  end

  always_comb begin
    out_valid_d = IN_VALID;
    out_data_d  = IN_VALID ? voted   : out_data_q;
    mismatch_d  = IN_VALID ? chan_mm : mismatch_q;
    fault_d     = '0;
    for (int k = 0; k < N; k++) begin
      st_d[k]  = st_q[k];
      cnt_d[k] = cnt_q[k];
      if (CLR_FAULT) begin
        st_d[k]  = ST_OK;
        cnt_d[k] = '0;
      end else if (IN_VALID) begin
        case (st_q[k])
          ST_OK: begin
            if (chan_mm[k]) begin
              cnt_d[k] = CW'(1);
              st_d[k]  = (ERR_LIMIT == 1) ? ST_FAULT : ST_SUSPECT;
            end
          end
          ST_SUSPECT: begin
            if (!chan_mm[k]) begin
              st_d[k]  = ST_OK;
              cnt_d[k] = '0;
            end else begin
              cnt_d[k] = cnt_q[k] + CW'(1);
              if ((cnt_q[k] + CW'(1)) == CW'(ERR_LIMIT)) st_d[k] = ST_FAULT;
            end
          end
          default: ;  // FAULT is sticky with a frozen counter
        endcase
      end
      fault_d[k] = (st_d[k] == ST_FAULT);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mismatch_q  <= '0;
      fault_q     <= '0;
      for (int k = 0; k < N; k++) begin
        st_q[k]  <= ST_OK;
        cnt_q[k] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      mismatch_q  <= mismatch_d;
      fault_q     <= fault_d;
      for (int k = 0; k < N; k++) begin
        st_q[k]  <= st_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign MISMATCH  = mismatch_q;
  assign FAULT     = fault_q;
  assign ALL_FAULT = &fault_q;

endmodule

// File: tb/tb_majority_voter_seq.sv
// Scenario and randomized bench for majority_voter_seq against a run-length reference model.
module tb_majority_voter_seq;
  localparam int N = 3;
  localparam int W = 8;
  localparam int LIM = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic           mask_en = 1'b0;
  logic           clr_fault = 1'b0;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [N-1:0]   mismatch;
  logic [N-1:0]   fault;
  logic           all_fault;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic           m_valid;
  logic [W-1:0]   m_data;
  logic [N-1:0]   m_mm;
  logic [N-1:0]   m_fault;
  int             m_run [N];

  majority_voter_seq #(.N(N), .W(W), .ERR_LIMIT(LIM)) dut (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_DATA(in_data),
    .MASK_EN(mask_en), .CLR_FAULT(clr_fault), .OUT_VALID(out_valid),
    .OUT_DATA(out_data), .MISMATCH(mismatch), .FAULT(fault), .ALL_FAULT(all_fault)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic [N-1:0] act;
    logic [W-1:0] v;
    int ones, cnt;
    if (!rst_n) begin
      m_valid = 0; m_data = '0; m_mm = '0; m_fault = '0;
      for (int k = 0; k < N; k++) m_run[k] = 0;
      return;
    end
    m_valid = in_valid;
    if (in_valid) begin
      for (int k = 0; k < N; k++) act[k] = !mask_en || !m_fault[k];
      for (int b = 0; b < W; b++) begin
        ones = 0; cnt = 0;
        for (int k = 0; k < N; k++) if (act[k]) begin
          cnt++;
          ones += int'(in_data[k*W+b]);
        end
        if (2*ones > cnt)      v[b] = 1'b1;
        else if (2*ones < cnt) v[b] = 1'b0;
        else                   v[b] = m_data[b];
      end
      m_data = v;
      for (int k = 0; k < N; k++) begin
        m_mm[k] = (in_data[k*W +: W] != v);
        if (!m_fault[k]) begin
          m_run[k] = m_mm[k] ? m_run[k] + 1 : 0;
          if (m_run[k] >= LIM) m_fault[k] = 1'b1;
        end
      end
    end
    if (clr_fault) begin
      m_fault = '0;
      for (int k = 0; k < N; k++) m_run[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [W-1:0] c2, input logic [W-1:0] c1, input logic [W-1:0] c0);
    in_valid = 1'b1;
    in_data  = {c2, c1, c0};
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = N*W'($urandom); mask_en = 1'b1; clr_fault = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid, out_data, mismatch, fault, all_fault} !== '0) begin
      n_err++;
      $display("FAIL reset: got v=%b d=%h mm=%b f=%b af=%b, want all zero",
               out_valid, out_data, mismatch, fault, all_fault);
    end
    rst_n = 1'b1; in_valid = 1'b0; mask_en = 1'b0;
    tick();
  endtask

  task automatic test_basic_vote();
    send(8'hAA, 8'hCC, 8'hF0);
    n_cmp++;
    if ({out_valid, out_data, mismatch} !== {1'b1, 8'hE8, 3'b111}) begin
      n_err++;
      $display("FAIL basic_vote: got v=%b d=%h mm=%b, want v=1 d=e8 mm=111", out_valid, out_data, mismatch);
    end
    tick();
    n_cmp++;
    if ({out_valid, out_data} !== {1'b0, 8'hE8}) begin
      n_err++;
      $display("FAIL basic_idle: got v=%b d=%h, want v=0 d=e8", out_valid, out_data);
    end
  endtask

  task automatic test_fault_run();
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(8'h00, 8'h5A, 8'h5A);
      tick();  // idle gap must not break the run
      n_cmp++;
      if (fault !== 3'b000) begin
        n_err++;
        $display("FAIL fault_run1_%0d: got fault=%b, want 000", i, fault);
      end
    end
    send(8'h5A, 8'h5A, 8'h5A);
    n_cmp++;
    if ({fault, mismatch} !== 6'b000_000) begin
      n_err++;
      $display("FAIL fault_match: got fault=%b mm=%b, want 000 000", fault, mismatch);
    end
    for (int i = 0; i < 4; i++) begin
      send(8'h00, 8'h5A, 8'h5A);
      n_cmp++;
      if (fault !== ((i == 3) ? 3'b100 : 3'b000)) begin
        n_err++;
        $display("FAIL fault_run2_%0d: got fault=%b, want %b", i, fault, (i == 3) ? 3'b100 : 3'b000);
      end
    end
  endtask

  task automatic test_masked_tie();
    mask_en = 1'b1;
    send(8'hFF, 8'hFF, 8'hFF);
    n_cmp++;
    if ({out_data, fault} !== {8'hFF, 3'b100}) begin
      n_err++;
      $display("FAIL tie_setup: got d=%h fault=%b, want ff 100", out_data, fault);
    end
    send(8'h00, 8'h3C, 8'h0F);
    n_cmp++;
    if (out_data !== 8'h3F) begin
      n_err++;
      $display("FAIL masked_tie: got d=%h, want 3f", out_data);
    end
    mask_en = 1'b0;
    send(8'h00, 8'h3C, 8'h0F);
    n_cmp++;
    if (out_data !== 8'h0C) begin
      n_err++;
      $display("FAIL unmasked_vote: got d=%h, want 0c", out_data);
    end
  endtask

  task automatic test_clear_collision();
    clr_fault = 1'b1;
    send(8'h22, 8'h11, 8'h11);
    clr_fault = 1'b0;
    n_cmp++;
    if ({fault, mismatch} !== {3'b000, 3'b100}) begin
      n_err++;
      $display("FAIL clear_collision: got fault=%b mm=%b, want 000 100", fault, mismatch);
    end
    for (int i = 0; i < LIM; i++) begin
      send(8'h22, 8'h11, 8'h11);
      n_cmp++;
      if (fault !== ((i == LIM-1) ? 3'b100 : 3'b000)) begin
        n_err++;
        $display("FAIL refault_%0d: got fault=%b, want %b", i, fault, (i == LIM-1) ? 3'b100 : 3'b000);
      end
    end
  endtask

  task automatic test_all_fault();
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    mask_en = 1'b0;
    for (int i = 0; i < LIM; i++) send(8'hAA, 8'hCC, 8'hF0);
    n_cmp++;
    if ({fault, all_fault, out_data} !== {3'b111, 1'b1, 8'hE8}) begin
      n_err++;
      $display("FAIL all_fault_set: got fault=%b af=%b d=%h, want 111 1 e8", fault, all_fault, out_data);
    end
    mask_en = 1'b1;
    send(8'h12, 8'h34, 8'h56);
    n_cmp++;
    if ({out_valid, out_data, all_fault} !== {1'b1, 8'hE8, 1'b1}) begin
      n_err++;
      $display("FAIL all_fault_hold: got v=%b d=%h af=%b, want 1 e8 1", out_valid, out_data, all_fault);
    end
    rst_n = 1'b0; in_valid = 1'b1; in_data = {8'h01, 8'h02, 8'h03};
    tick();
    n_cmp++;
    if ({out_valid, out_data, mismatch, fault, all_fault} !== '0) begin
      n_err++;
      $display("FAIL midrun_reset: got v=%b d=%h mm=%b f=%b af=%b, want all zero",
               out_valid, out_data, mismatch, fault, all_fault);
    end
    rst_n = 1'b1; in_valid = 1'b0; mask_en = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] base;
    int bad;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) bad = $urandom_range(0, N-1);
      base = W'($urandom);
      for (int k = 0; k < N; k++) begin
        if ((k == bad) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0))
          in_data[k*W +: W] = base ^ W'($urandom_range(1, 255));
        else
          in_data[k*W +: W] = base;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      mask_en   = ($urandom_range(0, 1) == 1);
      clr_fault = ($urandom_range(0, 39) == 0);
      rst_n     = ($urandom_range(0, 149) != 0);
      tick();
      n_cmp++;
      if ({out_valid, out_data, mismatch, fault, all_fault} !== {m_valid, m_data, m_mm, m_fault, &m_fault}) begin
        n_err++;
        $display("FAIL random_%0d: got v=%b d=%h mm=%b f=%b af=%b, want v=%b d=%h mm=%b f=%b af=%b",
                 i, out_valid, out_data, mismatch, fault, all_fault,
                 m_valid, m_data, m_mm, m_fault, &m_fault);
      end
    end
    rst_n = 1'b1; in_valid = 1'b0; clr_fault = 1'b0; mask_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_vote();
    test_fault_run();
    test_masked_tie();
    test_clear_collision();
    test_all_fault();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
